// File: rtl/parity_rx_pkg.sv
// -----------------------------------------------------------------------------
// parity_rx_pkg
// Shared definitions for the parity-protected serial link receiver.
//   rx_state_t     : receiver FSM states
//   START_BIT      : line level that marks the start of a frame
//   STOP_BIT       : line level required in the stop-bit slot
//   DATA_W_DEFAULT : default number of data bits per frame
// -----------------------------------------------------------------------------
package parity_rx_pkg;

   localparam logic START_BIT      = 1'b0;
   localparam logic STOP_BIT       = 1'b1;
   localparam int   DATA_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      PARITY    = 3'd2,
      STOP      = 3'd3,
      DONE      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_t;

endpackage

// File: rtl/serial_parity_acc.sv
// -----------------------------------------------------------------------------
// serial_parity_acc
// Running-XOR register for serial parity. Shared by transmitter and receiver.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (clears the accumulator)
//   clr_i    : synchronous clear, has priority over en_i
//   en_i     : fold bit_i into the running parity this cycle
//   bit_i    : serial bit to accumulate
//   parity_o : current running parity (XOR of all accumulated bits)
// -----------------------------------------------------------------------------
module serial_parity_acc (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   output logic parity_o
);

   logic parity_q;
   logic parity_d;

   always_comb begin
      parity_d = parity_q;
      if (clr_i) begin
         parity_d = 1'b0;
      end else if (en_i) begin
         parity_d = parity_q ^ bit_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_o = parity_q;

endmodule

// File: rtl/parity_serial_rx.sv
// -----------------------------------------------------------------------------
// parity_serial_rx
// Serial frame receiver with even-parity check, one bit per clock.
// Frame: start(0), DATA_W data bits LSB first, even parity bit, stop(1).
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   in         : serial line, synchronised to clk, idles high
//   out_byte   : last accepted data word (valid with done)
//   done       : one-cycle strobe for each accepted frame
//   parity_err : (only with PARITY_ERR_OUT_EN) flags done for a frame whose
//                parity failed; 0 whenever done=0
//   state_o    : debug view of the FSM state (rx_state_t encoding)
// Build option PARITY_ERR_OUT_EN: when defined, parity failures are delivered
// with parity_err=1; when undefined they are dropped silently.
// Handshake: no backpressure. done is a single-cycle strobe; out_byte is
// meaningful in that cycle and holds its value until the next accepted frame.
// -----------------------------------------------------------------------------
module parity_serial_rx
   import parity_rx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in,
   output logic [DATA_W-1:0] out_byte,
   output logic              done,
`ifdef PARITY_ERR_OUT_EN
   output logic              parity_err,
`endif
   output logic [2:0]        state_o
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] out_byte_q, out_byte_d;
   logic              done_q, done_d;
`ifdef PARITY_ERR_OUT_EN
   logic              perr_q, perr_d;
`endif

   logic acc_clr;
   logic acc_en;
   logic acc_parity;

   serial_parity_acc u_acc (
      .clk_i    (clk),
      .rst_i    (reset),
      .clr_i    (acc_clr),
      .en_i     (acc_en),
      .bit_i    (in),
      .parity_o (acc_parity)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      out_byte_d = out_byte_q;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;
`ifdef PARITY_ERR_OUT_EN
      perr_d     = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (in == START_BIT) begin
               state_d = DATA;
               cnt_d   = '0;
               acc_clr = 1'b1;
            end
         end

         DATA: begin
            // LSB-first: each new bit enters at the MSB and moves down.
            shift_d             = shift_q >> 1;
            shift_d[DATA_W-1]   = in;
            acc_en              = 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = PARITY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         PARITY: begin
            // After this bit the accumulator is 0 for an even-parity frame.
            acc_en  = 1'b1;
            state_d = STOP;
         end

         STOP: begin
            if (in == STOP_BIT) begin
               if (!acc_parity) begin
                  state_d    = DONE;
                  out_byte_d = shift_q;
               end else begin
`ifdef PARITY_ERR_OUT_EN
                  state_d    = DONE;
                  out_byte_d = shift_q;
                  perr_d     = 1'b1;
`else
                  state_d    = IDLE;
`endif
               end
            end else begin
               state_d = WAIT_IDLE;
            end
         end

         DONE: begin
            // A low line here is the next start bit (back-to-back frames).
            if (in == START_BIT) begin
               state_d = DATA;
               cnt_d   = '0;
               acc_clr = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         WAIT_IDLE: begin
            // Line must return high before a new start bit is honoured.
            if (in == STOP_BIT) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         out_byte_q <= '0;
         done_q     <= 1'b0;
`ifdef PARITY_ERR_OUT_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         out_byte_q <= out_byte_d;
         done_q     <= done_d;
`ifdef PARITY_ERR_OUT_EN
         perr_q     <= perr_d;
`endif
      end
   end

   assign out_byte = out_byte_q;
   assign done     = done_q;
   assign state_o  = state_q;
`ifdef PARITY_ERR_OUT_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_parity_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_serial_rx
// Directed frames from the test plan followed by randomized frame streams.
// A frame-level reference model decides whether each frame should be accepted
// and when its done strobe is due; a negedge monitor checks the DUT against
// the expected queues. Honours PARITY_ERR_OUT_EN like the design.
// -----------------------------------------------------------------------------
module tb_parity_serial_rx;
   import parity_rx_pkg::*;

   localparam int DATA_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic in;
   logic [DATA_W-1:0] out_byte;
   logic done;
   logic [2:0] state_o;
`ifdef PARITY_ERR_OUT_EN
   logic parity_err;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   parity_serial_rx #(.DATA_W(DATA_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .out_byte (out_byte),
      .done     (done),
`ifdef PARITY_ERR_OUT_EN
      .parity_err (parity_err),
`endif
      .state_o  (state_o)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [DATA_W-1:0] exp_q[$];
   logic              exp_perr_q[$];
   int                exp_cyc_q[$];
   logic [DATA_W-1:0] last_out = '0;
   bit                run_mon  = 1'b0;

   logic [DATA_W-1:0] mon_d;
   logic              mon_p;
   int                mon_c;

   // Frame-level reference: count ones over data+parity; even total is good.
   function automatic void model(input logic [DATA_W-1:0] d, input logic p, input logic s,
                                 output bit accept, output bit perr);
      int ones;
      bit par_ok;
      ones = 0;
      for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
      ones += int'(p);
      par_ok = ((ones % 2) == 0);
      perr   = !par_ok;
`ifdef PARITY_ERR_OUT_EN
      accept = (s == 1'b1);
`else
      accept = (s == 1'b1) && par_ok;
`endif
   endfunction

   always @(negedge clk) begin
      if (run_mon && !reset) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               mon_d = exp_q.pop_front();
               mon_p = exp_perr_q.pop_front();
               mon_c = exp_cyc_q.pop_front();
               check("done_cycle", cyc, mon_c);
               check("out_byte", out_byte, mon_d);
`ifdef PARITY_ERR_OUT_EN
               check("parity_err", parity_err, mon_p);
`endif
               last_out = mon_d;
            end
         end else begin
            check("out_byte_hold", out_byte, last_out);
`ifdef PARITY_ERR_OUT_EN
            check("parity_err_idle", parity_err, 32'd0);
`endif
            if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
               check("missing_done", 32'd0, 32'd1);
               void'(exp_q.pop_front());
               void'(exp_perr_q.pop_front());
               void'(exp_cyc_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      @(posedge clk);
      #1 in = b;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
      bit accept;
      bit perr;
      model(d, p, s, accept, perr);
      drive_bit(START_BIT);
      // Start bit is sampled at the next edge (cyc+1); done shows DATA_W+2 edges later.
      if (accept) begin
         exp_q.push_back(d);
         exp_perr_q.push_back(perr);
         exp_cyc_q.push_back(cyc + 1 + DATA_W + 2);
      end
      for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(s);
   endtask

   function automatic logic even_par(input logic [DATA_W-1:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
      return logic'(ones % 2);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] rd;
      logic              rp;
      logic              rs;

      reset = 1'b1;
      in    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_o, 32'(IDLE));
      check("rst_done", done, 32'd0);
      check("rst_out_byte", out_byte, 32'd0);
`ifdef PARITY_ERR_OUT_EN
      check("rst_parity_err", parity_err, 32'd0);
`endif
      reset   = 1'b0;
      run_mon = 1'b1;
      drive_bit(1'b1);

      // Good 0xA5, then odd-weight 0x07.
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Bad parity on 0xA5.
      send_frame(8'hA5, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Framing error, long low, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (3) drive_bit(1'b0);
      drive_bit(1'b1);
      send_frame(8'h81, 1'b0, 1'b1);
      drive_bit(1'b1);

      // Back-to-back frames.
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);

      // Reset after four data bits of 0xF0.
      drive_bit(START_BIT);
      repeat (4) drive_bit(1'b0);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in       = 1'b1;
      last_out = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_state", state_o, 32'(IDLE));
      check("midrst_done", done, 32'd0);
      check("midrst_out_byte", out_byte, 32'd0);
      drive_bit(1'b1);
      send_frame(8'h12, 1'b0, 1'b1);
      drive_bit(1'b1);

      // Randomized frame stream.
      for (int n = 0; n < 80; n++) begin
         rd = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         rp = even_par(rd) ^ ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 7) != 0);
         send_frame(rd, rp, rs);
         if (!rs) begin
            repeat ($urandom_range(0, 3)) drive_bit(1'b0);
            drive_bit(1'b1);
         end else begin
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
         end
      end

      repeat (DATA_W + 6) drive_bit(1'b1);
      check("exp_q_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
